id_ex_reg: RTL
==============

// Module: id_ex_reg
// PURPOSE
//  ID/EX pipeline register. Latches the main-decoder control bundle plus decode-stage operands into
//  the execute stage. Supports stall (hold) and flush (bubble insertion) for the hazard unit.
//  Keeps a saturating count of inserted bubbles for performance debug.
// PARAMETERS
//  XLEN     32  datapath width (operands, PC, immediate)
//  RAW      5   register-address width
//  CNTW     16  bubble-counter width
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst          in   1     asynchronous, active-high reset
//  stall_e      in   1     hold all E-stage contents this cycle
//  flush_e      in   1     load a bubble (all-zero bundle, valid_e=0) this cycle
//  valid_d      in   1     D-stage holds a real instruction
//  regwrite_d   in   1     decoder control: register write
//  memwrite_d   in   1     decoder control: memory write
//  branch_d     in   1     decoder control: conditional branch
//  jump_d       in   1     decoder control: JAL/JALR
//  jal_or_jalr_d in  1     0=JAL target PC+imm, 1=JALR target rs1+imm
//  alusrc_d     in   1     ALU B operand select (1=immediate)
//  alusrcU_d    in   1     ALU A operand select for LUI (1=zero)
//  aluop_d      in   2     ALU decode class
//  resultsrc_d  in   2     writeback select (00 ALU,01 mem,10 PC+4,11 U-imm path)
//  funct3_d     in   3     instruction funct3
//  funct7b5_d   in   1     instruction bit 30
//  rd1_d,rd2_d  in   XLEN  register-file read data
//  pc_d,pcplus4_d in XLEN  instruction PC and PC+4
//  immext_d     in   XLEN  sign/format-extended immediate
//  rs1_d,rs2_d,rd_d in RAW source/destination register addresses
//  <each *_d above> out  same width, suffix _e: registered copy
//  valid_e      out  1     E-stage holds a real instruction
//  bubble_cnt   out  CNTW  saturating count of flush cycles since reset
// BEHAVIOUR
//  - Reset (rst=1, async): every _e output, valid_e and bubble_cnt = 0 immediately, independent of clk.
//  - Latency: 1 cycle; _d value at edge N appears on _e after edge N.
//  - Per rising edge, priority flush_e > stall_e > load:
//    flush_e=1          : all _e fields <= 0, valid_e <= 0 (NOP bubble; regwrite/memwrite/branch/jump = 0)
//    flush_e=0,stall_e=1: all _e fields and valid_e hold
//    neither            : all _e fields <= _d, valid_e <= valid_d
//  - flush_e and stall_e both high: flush wins (bubble), hold is ignored.
//  - Load with valid_d=0: control fields regwrite/memwrite/branch/jump forced 0 in E; data fields still copied.
//  - Invariant: valid_e=0 implies regwrite_e=memwrite_e=branch_e=jump_e=0 (architectural no-op).
//  - bubble_cnt: +1 on every edge with flush_e=1 (incl. flush during stall); saturates at 2^CNTW-1, never wraps.
//  - No combinational path from any input to any output.
//  - rst asserted mid-stall or mid-flush: reset dominates; first edge after release obeys normal priority.
// TESTING
//  T1 reset: rst=1 with _d=all-ones -> all _e, valid_e, bubble_cnt = 0 before any clk edge
//  T2 load: R-type (regwrite_d=1,aluop_d=10,rd1_d=0x11,rd_d=5,valid_d=1) -> next cycle regwrite_e=1,
//     aluop_e=10, rd1_e=0x11, rd_e=5, valid_e=1
//  T3 stall: load SW (memwrite_d=1,immext_d=0x8), then stall_e=1 3 cycles with new _d -> _e keeps SW
//     values for 3 cycles; new values appear 1 cycle after stall_e drops
//  T4 flush+stall: stall_e=1,flush_e=1 on a JAL (jump_d=1) -> valid_e=0, jump_e=0, rd_e=0, bubble_cnt+1
//  T5 invalid: valid_d=0, regwrite_d=1, branch_d=1 -> regwrite_e=0, branch_e=0, valid_e=0, rd1_e copied
//  T6 saturation: CNTW=4, flush_e=1 for 20 cycles -> bubble_cnt stops at 15; rst pulse -> 0

Source files
------------

// File: rtl/id_ex_if.sv
// Signal bundle between the decode-stage driver and the ID/EX pipeline register.
// The master side drives the D-stage bundle and hazard controls; the slave side returns the E-stage copy.
interface id_ex_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int CNTW = 16
);
  logic            stall_e, flush_e;
  logic            valid_d, regwrite_d, memwrite_d, branch_d, jump_d, jal_or_jalr_d;
  logic            alusrc_d, alusrcU_d, funct7b5_d;
  logic [1:0]      aluop_d, resultsrc_d;
  logic [2:0]      funct3_d;
  logic [XLEN-1:0] rd1_d, rd2_d, pc_d, pcplus4_d, immext_d;
  logic [RAW-1:0]  rs1_d, rs2_d, rd_d;

  logic            valid_e, regwrite_e, memwrite_e, branch_e, jump_e, jal_or_jalr_e;
  logic            alusrc_e, alusrcU_e, funct7b5_e;
  logic [1:0]      aluop_e, resultsrc_e;
  logic [2:0]      funct3_e;
  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pcplus4_e, immext_e;
  logic [RAW-1:0]  rs1_e, rs2_e, rd_e;
  logic [CNTW-1:0] bubble_cnt;

  modport master (
    output stall_e, flush_e, valid_d, regwrite_d, memwrite_d, branch_d, jump_d, jal_or_jalr_d,
           alusrc_d, alusrcU_d, funct7b5_d, aluop_d, resultsrc_d, funct3_d,
           rd1_d, rd2_d, pc_d, pcplus4_d, immext_d, rs1_d, rs2_d, rd_d,
    input  valid_e, regwrite_e, memwrite_e, branch_e, jump_e, jal_or_jalr_e,
           alusrc_e, alusrcU_e, funct7b5_e, aluop_e, resultsrc_e, funct3_e,
           rd1_e, rd2_e, pc_e, pcplus4_e, immext_e, rs1_e, rs2_e, rd_e, bubble_cnt
  );

  modport slave (
    input  stall_e, flush_e, valid_d, regwrite_d, memwrite_d, branch_d, jump_d, jal_or_jalr_d,
           alusrc_d, alusrcU_d, funct7b5_d, aluop_d, resultsrc_d, funct3_d,
           rd1_d, rd2_d, pc_d, pcplus4_d, immext_d, rs1_d, rs2_d, rd_d,
    output valid_e, regwrite_e, memwrite_e, branch_e, jump_e, jal_or_jalr_e,
           alusrc_e, alusrcU_e, funct7b5_e, aluop_e, resultsrc_e, funct3_e,
           rd1_e, rd2_e, pc_e, pcplus4_e, immext_e, rs1_e, rs2_e, rd_e, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hold (stall), bubble insertion (flush, highest priority)
// and a saturating counter of inserted bubbles.
module id_ex_reg #(
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int CNTW = 16
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // D -> E boundary: flush loads an all-zero bubble, stall holds, otherwise load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flush_e) begin
      bus.valid_e       <= 1'b0;
      bus.regwrite_e    <= 1'b0;
      bus.memwrite_e    <= 1'b0;
      bus.branch_e      <= 1'b0;
      bus.jump_e        <= 1'b0;
      bus.jal_or_jalr_e <= 1'b0;
      bus.alusrc_e      <= 1'b0;
      bus.alusrcU_e     <= 1'b0;
      bus.funct7b5_e    <= 1'b0;
      bus.aluop_e       <= '0;
      bus.resultsrc_e   <= '0;
      bus.funct3_e      <= '0;
      bus.rd1_e         <= '0;
      bus.rd2_e         <= '0;
      bus.pc_e          <= '0;
      bus.pcplus4_e     <= '0;
      bus.immext_e      <= '0;
      bus.rs1_e         <= '0;
      bus.rs2_e         <= '0;
      bus.rd_e          <= '0;
    end else if (!bus.stall_e) begin
      // Side-effecting controls are qualified by valid so an invalid slot is a true no-op.
      bus.valid_e       <= bus.valid_d;
      bus.regwrite_e    <= bus.regwrite_d & bus.valid_d;
      bus.memwrite_e    <= bus.memwrite_d & bus.valid_d;
      bus.branch_e      <= bus.branch_d   & bus.valid_d;
      bus.jump_e        <= bus.jump_d     & bus.valid_d;
      bus.jal_or_jalr_e <= bus.jal_or_jalr_d;
      bus.alusrc_e      <= bus.alusrc_d;
      bus.alusrcU_e     <= bus.alusrcU_d;
      bus.funct7b5_e    <= bus.funct7b5_d;
      bus.aluop_e       <= bus.aluop_d;
      bus.resultsrc_e   <= bus.resultsrc_d;
      bus.funct3_e      <= bus.funct3_d;
      bus.rd1_e         <= bus.rd1_d;
      bus.rd2_e         <= bus.rd2_d;
      bus.pc_e          <= bus.pc_d;
      bus.pcplus4_e     <= bus.pcplus4_d;
      bus.immext_e      <= bus.immext_d;
      bus.rs1_e         <= bus.rs1_d;
      bus.rs2_e         <= bus.rs2_d;
      bus.rd_e          <= bus.rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bubble_cnt <= '0;
    end else if (bus.flush_e) begin
      bus.bubble_cnt <= sat_inc(bus.bubble_cnt);
    end
  end

endmodule
